id_ex_stage: RTL and testbench

ID/EX pipeline stage of the RV32I core. It sits directly downstream of the decode control unit and captures its control bundle together with the operands, register addresses and PC. It forwards them to EX one cycle later. It also detects load-use hazards, inserts bubbles, honours branch/jump flushes and EX back-pressure, and counts inserted bubbles for performance monitoring.

---
 rtl/rv32_ctrl_pkg.sv | 42 ++++
 rtl/id_ex_stage_hazard_detect.sv | 35 +++
 rtl/id_ex_stage.sv | 160 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_ctrl_pkg.sv
// Decode control bundle layout and write-back source encodings shared by
// the decode unit and the ID/EX stage.
package rv32_ctrl_pkg;

    // The ALU_Ctrl field sits on top of a fixed 10-bit block of single-bit flags.
    localparam int CTRL_FIXED_W       = 10;
    localparam int ALU_DECODER_IN_DEF = 3;
    localparam int CTRL_W             = CTRL_FIXED_W + ALU_DECODER_IN_DEF;

    localparam int MEM_WR_EN_BIT      = 0;
    localparam int SRC_TO_REG_LSB     = 1;
    localparam int SRC_TO_REG_MSB     = 2;
    localparam int REG_WR_EN_BIT      = 3;
    localparam int ALU_SRC1_SEL_BIT   = 4;
    localparam int ALU_SRC2_SEL_BIT   = 5;
    localparam int SUB_BIT            = 6;
    localparam int BRANCH_BIT         = 7;
    localparam int JUMP_BIT           = 8;
    localparam int UNDEF_INSTR_BIT    = 9;
    localparam int ALU_CTRL_LSB       = 10;

    typedef enum logic [1:0] {
        SRC_ALU = 2'b00,
        SRC_MEM = 2'b01,
        SRC_PC4 = 2'b10
    } src_to_reg_e;

    // Field view of the default-width bundle; the first member is the MSB.
    typedef struct packed {
        logic [ALU_DECODER_IN_DEF-1:0] alu_ctrl;
        logic                          undef_instr;
        logic                          jump;
        logic                          branch;
        logic                          sub;
        logic                          alu_src2_sel;
        logic                          alu_src1_sel;
        logic                          reg_wr_en;
        src_to_reg_e                   src_to_reg;
        logic                          mem_wr_en;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use comparator: the instruction in EX is a load whose
// destination is a source of the instruction currently in decode.
module hazard_detect
    import rv32_ctrl_pkg::*;
(
    input  logic       i_id_valid,
    input  logic       i_ex_valid,
    input  logic       i_ex_reg_wr_en,
    input  logic [1:0] i_ex_src_to_reg,
    input  logic [4:0] i_ex_rd_addr,
    input  logic [4:0] i_rs1_addr,
    input  logic [4:0] i_rs2_addr,
    input  logic       i_flush,
    input  logic       i_stall_ex,
    output logic       o_load_use_stall
);

    logic w_ex_is_load;
    logic w_rd_nonzero;
    logic w_src_match;
    logic w_raw_hazard;

    assign w_ex_is_load = i_ex_valid && i_ex_reg_wr_en &&
                          (i_ex_src_to_reg == SRC_MEM);
    // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
    assign w_rd_nonzero = (i_ex_rd_addr != 5'd0);
    assign w_src_match  = (i_rs1_addr == i_ex_rd_addr) ||
                          (i_rs2_addr == i_ex_rd_addr);
    assign w_raw_hazard = i_id_valid && w_ex_is_load && w_rd_nonzero && w_src_match;

    // A flush kills the consumer and a stall keeps the load in EX, so neither
    // cycle may freeze the front end on the hazard's behalf.
    assign o_load_use_stall = w_raw_hazard && !i_flush && !i_stall_ex;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the RV32I core with load-use bubble insertion,
// flush / back-pressure handling and a saturating bubble counter.
module id_ex_stage
    import rv32_ctrl_pkg::*;
#(
    parameter int ALU_DECODER_IN = 3,
    parameter int XLEN           = 32,
    parameter int CNT_W          = 16
) (
    input  logic                                   CLK,
    input  logic                                   rst_n,
    input  logic                                   ID_Valid,
    input  logic [CTRL_FIXED_W+ALU_DECODER_IN-1:0] Ctrl_In,
    input  logic [2:0]                             Funct3_In,
    input  logic [XLEN-1:0]                        PC_In,
    input  logic [XLEN-1:0]                        Rs1_Data_In,
    input  logic [XLEN-1:0]                        Rs2_Data_In,
    input  logic [XLEN-1:0]                        Imm_In,
    input  logic [4:0]                             Rs1_Addr_In,
    input  logic [4:0]                             Rs2_Addr_In,
    input  logic [4:0]                             Rd_Addr_In,
    input  logic                                   Flush,
    input  logic                                   Stall_EX,
    output logic                                   EX_Valid,
    output logic [CTRL_FIXED_W+ALU_DECODER_IN-1:0] EX_Ctrl,
    output logic [2:0]                             EX_Funct3,
    output logic [XLEN-1:0]                        EX_PC,
    output logic [XLEN-1:0]                        EX_Rs1_Data,
    output logic [XLEN-1:0]                        EX_Rs2_Data,
    output logic [XLEN-1:0]                        EX_Imm,
    output logic [4:0]                             EX_Rs1_Addr,
    output logic [4:0]                             EX_Rs2_Addr,
    output logic [4:0]                             EX_Rd_Addr,
    output logic                                   EX_Trap,
    output logic                                   Load_Use_Stall,
    output logic [CNT_W-1:0]                       Bubble_Cnt
);

    localparam int BUNDLE_W = CTRL_FIXED_W + ALU_DECODER_IN;

    logic                r_ex_valid;
    logic [BUNDLE_W-1:0] r_ex_ctrl;
    logic                r_ex_trap;
    logic [2:0]          r_ex_funct3;
    logic [XLEN-1:0]     r_ex_pc;
    logic [XLEN-1:0]     r_ex_rs1_data;
    logic [XLEN-1:0]     r_ex_rs2_data;
    logic [XLEN-1:0]     r_ex_imm;
    logic [4:0]          r_ex_rs1_addr;
    logic [4:0]          r_ex_rs2_addr;
    logic [4:0]          r_ex_rd_addr;
    logic [CNT_W-1:0]    r_bubble_cnt;

    logic                w_load_use;
    logic [BUNDLE_W-1:0] w_ctrl_gated;
    logic                w_trap_next;
    logic                w_cnt_saturated;

    hazard_detect u_hazard_detect (
        .i_id_valid       (ID_Valid),
        .i_ex_valid       (r_ex_valid),
        .i_ex_reg_wr_en   (r_ex_ctrl[REG_WR_EN_BIT]),
        .i_ex_src_to_reg  (r_ex_ctrl[SRC_TO_REG_MSB:SRC_TO_REG_LSB]),
        .i_ex_rd_addr     (r_ex_rd_addr),
        .i_rs1_addr       (Rs1_Addr_In),
        .i_rs2_addr       (Rs2_Addr_In),
        .i_flush          (Flush),
        .i_stall_ex       (Stall_EX),
        .o_load_use_stall (w_load_use)
    );

    // A NOP slot must never carry stray write enables into EX.
    assign w_ctrl_gated    = ID_Valid ? Ctrl_In : '0;
    assign w_trap_next     = ID_Valid && Ctrl_In[UNDEF_INSTR_BIT];
    assign w_cnt_saturated = (r_bubble_cnt == {CNT_W{1'b1}});

    // Valid, control bundle and trap flag. Priority: flush, stall, bubble, capture.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid <= 1'b0;
            r_ex_ctrl  <= '0;
            r_ex_trap  <= 1'b0;
        end else if (Flush) begin
            r_ex_valid <= 1'b0;
            r_ex_ctrl  <= '0;
            r_ex_trap  <= 1'b0;
        end else if (Stall_EX) begin
            r_ex_valid <= r_ex_valid;
            r_ex_ctrl  <= r_ex_ctrl;
            r_ex_trap  <= r_ex_trap;
        end else if (w_load_use) begin
            r_ex_valid <= 1'b0;
            r_ex_ctrl  <= '0;
            r_ex_trap  <= 1'b0;
        end else begin
            r_ex_valid <= ID_Valid;
            r_ex_ctrl  <= w_ctrl_gated;
            r_ex_trap  <= w_trap_next;
        end
    end

    // Operand payload. Its contents behind a bubble are never consumed, so the
    // bubble path simply keeps capturing; a flush clears it for clean traces.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_funct3   <= '0;
            r_ex_pc       <= '0;
            r_ex_rs1_data <= '0;
            r_ex_rs2_data <= '0;
            r_ex_imm      <= '0;
            r_ex_rs1_addr <= '0;
            r_ex_rs2_addr <= '0;
            r_ex_rd_addr  <= '0;
        end else if (Flush) begin
            r_ex_funct3   <= '0;
            r_ex_pc       <= '0;
            r_ex_rs1_data <= '0;
            r_ex_rs2_data <= '0;
            r_ex_imm      <= '0;
            r_ex_rs1_addr <= '0;
            r_ex_rs2_addr <= '0;
            r_ex_rd_addr  <= '0;
        end else if (!Stall_EX) begin
            r_ex_funct3   <= Funct3_In;
            r_ex_pc       <= PC_In;
            r_ex_rs1_data <= Rs1_Data_In;
            r_ex_rs2_data <= Rs2_Data_In;
            r_ex_imm      <= Imm_In;
            r_ex_rs1_addr <= Rs1_Addr_In;
            r_ex_rs2_addr <= Rs2_Addr_In;
            r_ex_rd_addr  <= Rd_Addr_In;
        end
    end

    // Performance counter: counts only bubbles actually inserted, never wraps.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (!Flush && !Stall_EX && w_load_use && !w_cnt_saturated) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign EX_Valid       = r_ex_valid;
    assign EX_Ctrl        = r_ex_ctrl;
    assign EX_Trap        = r_ex_trap;
    assign EX_Funct3      = r_ex_funct3;
    assign EX_PC          = r_ex_pc;
    assign EX_Rs1_Data    = r_ex_rs1_data;
    assign EX_Rs2_Data    = r_ex_rs2_data;
    assign EX_Imm         = r_ex_imm;
    assign EX_Rs1_Addr    = r_ex_rs1_addr;
    assign EX_Rs2_Addr    = r_ex_rs2_addr;
    assign EX_Rd_Addr     = r_ex_rd_addr;
    assign Load_Use_Stall = w_load_use;
    assign Bubble_Cnt     = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, capture, load-use, x0, flush
// precedence, back-pressure, trap, counter saturation and async reset.
module tb_id_ex_stage;

    localparam logic [12:0] CTRL_ADD   = 13'h0008; // Reg_Wr_En, SRC_ALU
    localparam logic [12:0] CTRL_LOAD  = 13'h002A; // Reg_Wr_En, SRC_MEM, ALU_Src2_Sel
    localparam logic [12:0] CTRL_UNDEF = 13'h0200; // undef_instr only

    logic        CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic        ID_Valid = 1'b0;
    logic [12:0] Ctrl_In = '0;
    logic [2:0]  Funct3_In = '0;
    logic [31:0] PC_In = '0;
    logic [31:0] Rs1_Data_In = '0;
    logic [31:0] Rs2_Data_In = '0;
    logic [31:0] Imm_In = '0;
    logic [4:0]  Rs1_Addr_In = '0;
    logic [4:0]  Rs2_Addr_In = '0;
    logic [4:0]  Rd_Addr_In = '0;
    logic        Flush = 1'b0;
    logic        Stall_EX = 1'b0;

    logic        EX_Valid;
    logic [12:0] EX_Ctrl;
    logic [2:0]  EX_Funct3;
    logic [31:0] EX_PC;
    logic [31:0] EX_Rs1_Data;
    logic [31:0] EX_Rs2_Data;
    logic [31:0] EX_Imm;
    logic [4:0]  EX_Rs1_Addr;
    logic [4:0]  EX_Rs2_Addr;
    logic [4:0]  EX_Rd_Addr;
    logic        EX_Trap;
    logic        Load_Use_Stall;
    logic [3:0]  Bubble_Cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 CLK = ~CLK;

    id_ex_stage #(
        .ALU_DECODER_IN (3),
        .XLEN           (32),
        .CNT_W          (4)
    ) dut (
        .CLK            (CLK),
        .rst_n          (rst_n),
        .ID_Valid       (ID_Valid),
        .Ctrl_In        (Ctrl_In),
        .Funct3_In      (Funct3_In),
        .PC_In          (PC_In),
        .Rs1_Data_In    (Rs1_Data_In),
        .Rs2_Data_In    (Rs2_Data_In),
        .Imm_In         (Imm_In),
        .Rs1_Addr_In    (Rs1_Addr_In),
        .Rs2_Addr_In    (Rs2_Addr_In),
        .Rd_Addr_In     (Rd_Addr_In),
        .Flush          (Flush),
        .Stall_EX       (Stall_EX),
        .EX_Valid       (EX_Valid),
        .EX_Ctrl        (EX_Ctrl),
        .EX_Funct3      (EX_Funct3),
        .EX_PC          (EX_PC),
        .EX_Rs1_Data    (EX_Rs1_Data),
        .EX_Rs2_Data    (EX_Rs2_Data),
        .EX_Imm         (EX_Imm),
        .EX_Rs1_Addr    (EX_Rs1_Addr),
        .EX_Rs2_Addr    (EX_Rs2_Addr),
        .EX_Rd_Addr     (EX_Rd_Addr),
        .EX_Trap        (EX_Trap),
        .Load_Use_Stall (Load_Use_Stall),
        .Bubble_Cnt     (Bubble_Cnt)
    );

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic [12:0] c, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] d1);
        ID_Valid    = v;
        Ctrl_In     = c;
        Rs1_Addr_In = rs1;
        Rs2_Addr_In = rs2;
        Rd_Addr_In  = rd;
        Rs1_Data_In = d1;
        Rs2_Data_In = d1 ^ 32'hFFFF_0000;
        Imm_In      = {27'd0, rd};
        PC_In       = 32'h0000_1000 + d1;
        Funct3_In   = rd[2:0];
    endtask

    task automatic test_reset();
        set_instr(1'b1, CTRL_LOAD, 5'd1, 5'd2, 5'd3, 32'hDEAD_BEEF);
        rst_n = 1'b0;
        repeat (3) step();
        tests_run++;
        if (EX_Valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_valid: got %b expected 0", EX_Valid);
        end
        tests_run++;
        if (EX_Ctrl !== 13'h0) begin
            tests_failed++; $display("FAIL reset_ctrl: got %h expected 0000", EX_Ctrl);
        end
        tests_run++;
        if (Bubble_Cnt !== 4'd0) begin
            tests_failed++; $display("FAIL reset_bubble_cnt: got %0d expected 0", Bubble_Cnt);
        end
        tests_run++;
        if (EX_Rs1_Data !== 32'h0 || EX_PC !== 32'h0 || EX_Trap !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_data: got rs1=%h pc=%h trap=%b expected all 0", EX_Rs1_Data, EX_PC, EX_Trap);
        end
        #4 rst_n = 1'b1;
    endtask

    task automatic test_capture();
        set_instr(1'b1, CTRL_ADD, 5'd1, 5'd2, 5'd3, 32'd5);
        step();
        tests_run++;
        if (EX_Valid !== 1'b1 || EX_Ctrl !== CTRL_ADD) begin
            tests_failed++;
            $display("FAIL capture_ctrl: got valid=%b ctrl=%h expected 1/%h", EX_Valid, EX_Ctrl, CTRL_ADD);
        end
        tests_run++;
        if (EX_Rs1_Data !== 32'd5 || EX_Rs2_Data !== 32'hFFFF_0005 || EX_PC !== 32'h0000_1005) begin
            tests_failed++;
            $display("FAIL capture_data: got rs1=%h rs2=%h pc=%h expected 00000005/ffff0005/00001005",
                     EX_Rs1_Data, EX_Rs2_Data, EX_PC);
        end
        tests_run++;
        if (EX_Rs1_Addr !== 5'd1 || EX_Rs2_Addr !== 5'd2 || EX_Rd_Addr !== 5'd3 ||
            EX_Imm !== 32'd3 || EX_Funct3 !== 3'd3) begin
            tests_failed++;
            $display("FAIL capture_addr: got rs1a=%0d rs2a=%0d rd=%0d imm=%h f3=%0d expected 1/2/3/3/3",
                     EX_Rs1_Addr, EX_Rs2_Addr, EX_Rd_Addr, EX_Imm, EX_Funct3);
        end
    endtask

    task automatic test_load_use();
        set_instr(1'b1, CTRL_LOAD, 5'd1, 5'd2, 5'd7, 32'h100);
        step();
        set_instr(1'b1, CTRL_ADD, 5'd3, 5'd7, 5'd8, 32'h200);
        #1;
        tests_run++;
        if (Load_Use_Stall !== 1'b1) begin
            tests_failed++; $display("FAIL load_use_detect: got %b expected 1", Load_Use_Stall);
        end
        step();
        tests_run++;
        if (EX_Valid !== 1'b0 || EX_Ctrl !== 13'h0 || Bubble_Cnt !== 4'd1) begin
            tests_failed++;
            $display("FAIL load_use_bubble: got valid=%b ctrl=%h cnt=%0d expected 0/0000/1",
                     EX_Valid, EX_Ctrl, Bubble_Cnt);
        end
        tests_run++;
        if (Load_Use_Stall !== 1'b0) begin
            tests_failed++; $display("FAIL load_use_one_cycle: got %b expected 0", Load_Use_Stall);
        end
        step();
        tests_run++;
        if (EX_Valid !== 1'b1 || EX_Rd_Addr !== 5'd8 || EX_Ctrl !== CTRL_ADD || Bubble_Cnt !== 4'd1) begin
            tests_failed++;
            $display("FAIL load_use_replay: got valid=%b rd=%0d ctrl=%h cnt=%0d expected 1/8/%h/1",
                     EX_Valid, EX_Rd_Addr, EX_Ctrl, Bubble_Cnt, CTRL_ADD);
        end
    endtask

    task automatic test_x0();
        set_instr(1'b1, CTRL_LOAD, 5'd1, 5'd2, 5'd0, 32'h300);
        step();
        set_instr(1'b1, CTRL_ADD, 5'd0, 5'd0, 5'd9, 32'h400);
        #1;
        tests_run++;
        if (Load_Use_Stall !== 1'b0) begin
            tests_failed++; $display("FAIL x0_no_stall: got %b expected 0", Load_Use_Stall);
        end
        step();
        tests_run++;
        if (EX_Valid !== 1'b1 || EX_Rd_Addr !== 5'd9 || Bubble_Cnt !== 4'd1) begin
            tests_failed++;
            $display("FAIL x0_capture: got valid=%b rd=%0d cnt=%0d expected 1/9/1", EX_Valid, EX_Rd_Addr, Bubble_Cnt);
        end
    endtask

    task automatic test_flush_precedence();
        set_instr(1'b1, CTRL_LOAD, 5'd1, 5'd2, 5'd5, 32'h500);
        step();
        set_instr(1'b1, CTRL_ADD, 5'd5, 5'd6, 5'd11, 32'h600);
        Flush = 1'b1;
        #1;
        tests_run++;
        if (Load_Use_Stall !== 1'b0) begin
            tests_failed++; $display("FAIL flush_masks_stall: got %b expected 0", Load_Use_Stall);
        end
        step();
        Flush = 1'b0;
        tests_run++;
        if (EX_Valid !== 1'b0 || EX_Ctrl !== 13'h0 || Bubble_Cnt !== 4'd1) begin
            tests_failed++;
            $display("FAIL flush_wins: got valid=%b ctrl=%h cnt=%0d expected 0/0000/1", EX_Valid, EX_Ctrl, Bubble_Cnt);
        end
    endtask

    task automatic test_stall();
        set_instr(1'b1, CTRL_LOAD, 5'd1, 5'd2, 5'd10, 32'h11);
        step();
        Stall_EX = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_instr(1'b1, (i % 2 == 0) ? CTRL_ADD : CTRL_UNDEF, 5'd10, 5'(i), 5'(20 + i), 32'h7000 + i);
            #1;
            tests_run++;
            if (Load_Use_Stall !== 1'b0) begin
                tests_failed++; $display("FAIL stall_masks_hazard[%0d]: got %b expected 0", i, Load_Use_Stall);
            end
            step();
            tests_run++;
            if (EX_Valid !== 1'b1 || EX_Ctrl !== CTRL_LOAD || EX_Rd_Addr !== 5'd10 ||
                EX_Rs1_Data !== 32'h11 || EX_PC !== 32'h0000_1011 || EX_Trap !== 1'b0 || Bubble_Cnt !== 4'd1) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: got valid=%b ctrl=%h rd=%0d rs1=%h pc=%h trap=%b cnt=%0d expected 1/%h/10/00000011/00001011/0/1",
                         i, EX_Valid, EX_Ctrl, EX_Rd_Addr, EX_Rs1_Data, EX_PC, EX_Trap, Bubble_Cnt, CTRL_LOAD);
            end
        end
        Stall_EX = 1'b0;
        set_instr(1'b1, CTRL_ADD, 5'd1, 5'd2, 5'd12, 32'h22);
        step();
        tests_run++;
        if (EX_Valid !== 1'b1 || EX_Rd_Addr !== 5'd12 || EX_Rs1_Data !== 32'h22 || EX_Ctrl !== CTRL_ADD) begin
            tests_failed++;
            $display("FAIL stall_release: got valid=%b rd=%0d rs1=%h ctrl=%h expected 1/12/00000022/%h",
                     EX_Valid, EX_Rd_Addr, EX_Rs1_Data, EX_Ctrl, CTRL_ADD);
        end
    endtask

    task automatic test_trap();
        set_instr(1'b1, CTRL_UNDEF, 5'd1, 5'd2, 5'd3, 32'h33);
        step();
        tests_run++;
        if (EX_Trap !== 1'b1 || EX_Ctrl !== CTRL_UNDEF) begin
            tests_failed++; $display("FAIL trap_valid: got trap=%b ctrl=%h expected 1/%h", EX_Trap, EX_Ctrl, CTRL_UNDEF);
        end
        set_instr(1'b0, CTRL_UNDEF, 5'd1, 5'd2, 5'd3, 32'h44);
        step();
        tests_run++;
        if (EX_Trap !== 1'b0 || EX_Valid !== 1'b0 || EX_Ctrl !== 13'h0) begin
            tests_failed++;
            $display("FAIL trap_nop: got trap=%b valid=%b ctrl=%h expected 0/0/0000", EX_Trap, EX_Valid, EX_Ctrl);
        end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        exp_cnt = 1;
        for (int i = 0; i < 20; i++) begin
            set_instr(1'b1, CTRL_LOAD, 5'd1, 5'd2, 5'd7, 32'h800 + i);
            step();
            set_instr(1'b1, CTRL_ADD, 5'd3, 5'd7, 5'd8, 32'h900 + i);
            step();
            exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
            tests_run++;
            if (Bubble_Cnt !== 4'(exp_cnt) || EX_Valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL saturation[%0d]: got cnt=%0d valid=%b expected %0d/0", i, Bubble_Cnt, EX_Valid, exp_cnt);
            end
        end
        tests_run++;
        if (Bubble_Cnt !== 4'd15) begin
            tests_failed++; $display("FAIL saturation_final: got %0d expected 15", Bubble_Cnt);
        end
    endtask

    task automatic test_async_reset();
        set_instr(1'b1, CTRL_LOAD, 5'd1, 5'd2, 5'd7, 32'hA00);
        step();
        set_instr(1'b1, CTRL_ADD, 5'd3, 5'd7, 5'd8, 32'hB00);
        #1;
        tests_run++;
        if (Load_Use_Stall !== 1'b1 || EX_Valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_setup: got stall=%b valid=%b expected 1/1", Load_Use_Stall, EX_Valid);
        end
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if (EX_Valid !== 1'b0 || EX_Ctrl !== 13'h0 || Bubble_Cnt !== 4'd0 || Load_Use_Stall !== 1'b0 ||
            EX_Rd_Addr !== 5'd0 || EX_Rs1_Data !== 32'h0 || EX_PC !== 32'h0 || EX_Trap !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got valid=%b ctrl=%h cnt=%0d stall=%b rd=%0d rs1=%h pc=%h trap=%b expected all 0",
                     EX_Valid, EX_Ctrl, Bubble_Cnt, Load_Use_Stall, EX_Rd_Addr, EX_Rs1_Data, EX_PC, EX_Trap);
        end
        step();
        #3 rst_n = 1'b1;
        set_instr(1'b1, CTRL_ADD, 5'd4, 5'd5, 5'd6, 32'hC00);
        step();
        tests_run++;
        if (EX_Valid !== 1'b1 || EX_Rd_Addr !== 5'd6 || EX_Rs1_Data !== 32'hC00 || Bubble_Cnt !== 4'd0) begin
            tests_failed++;
            $display("FAIL post_reset_capture: got valid=%b rd=%0d rs1=%h cnt=%0d expected 1/6/00000c00/0",
                     EX_Valid, EX_Rd_Addr, EX_Rs1_Data, Bubble_Cnt);
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_load_use();
        test_x0();
        test_flush_precedence();
        test_stall();
        test_trap();
        test_saturation();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
